// File: rtl/line_clear.sv
// Row-clear stage: removes full rows from the landed 22x10 playfield, compacts
// the survivors toward row 21 and zero-fills the top. Fixed 23-cycle latency.
module line_clear (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [21:0][9:0]  grid_in,
    output logic [21:0][9:0]  grid_out,
    output logic [4:0]        lines_cleared,
    output logic [15:0]       lines_total,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

    state_t state, state_nx;

    logic [21:0][9:0] work;
    logic [21:0][9:0] work_filled;
    logic [4:0]       rd;
    logic [4:0]       wr;
    logic [4:0]       cnt;
    logic [16:0]      total_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (rd == 5'd0) state_nx = FILL;
            end
            FILL: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // After compaction the survivors occupy rows cnt..21, so rows below cnt are stale.
    always_comb begin
        work_filled = work;
        for (int unsigned i = 0; i < 22; i++) begin
            if (i < {27'd0, cnt}) work_filled[i] = '0;
        end
    end

    assign total_sum = {1'b0, lines_total} + {12'd0, cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work          <= '0;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            grid_out      <= '0;
            lines_cleared <= '0;
            lines_total   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= grid_in;
                        rd   <= 5'd21;
                        wr   <= 5'd21;
                        cnt  <= '0;
                    end
                end
                SCAN: begin
                    if (&work[rd]) begin
                        cnt <= cnt + 5'd1;
                    end else begin
                        work[wr] <= work[rd];
                        wr       <= wr - 5'd1;
                    end
                    rd <= rd - 5'd1;
                end
                FILL: begin
                    work          <= work_filled;
                    grid_out      <= work_filled;
                    lines_cleared <= cnt;
                    lines_total   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Scoreboard bench for line_clear: expected results are queued at the start
// edge and compared when done pulses.
module tb_line_clear;

    typedef logic [21:0][9:0] grid_t;

    typedef struct {
        grid_t       grid;
        logic [4:0]  lines;
        logic [15:0] total;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    grid_t       grid_in;
    grid_t       grid_out;
    logic [4:0]  lines_cleared;
    logic [15:0] lines_total;
    logic        busy;
    logic        done;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    done_count = 0;
    int    model_total = 0;
    grid_t last_grid = '0;

    line_clear dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .grid_in       (grid_in),
        .grid_out      (grid_out),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    task automatic check(input string tag, input logic [219:0] got, input logic [219:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input grid_t g);
        exp_t e;
        int   w = 21;
        int   n = 0;
        e.grid = '0;
        for (int r = 21; r >= 0; r--) begin
            if (g[r] == 10'h3FF) n++;
            else begin
                e.grid[w] = g[r];
                w--;
            end
        end
        model_total = model_total + n;
        if (model_total > 65535) model_total = 65535;
        e.lines = n[4:0];
        e.total = model_total[15:0];
        return e;
    endfunction

    // Leaves the caller at the falling edge right after the start-sampling edge.
    task automatic start_op(input grid_t g);
        @(negedge clk);
        grid_in = g;
        start   = 1'b1;
        @(posedge clk);
        sb.push_back(model(g));
        @(negedge clk);
        start   = 1'b0;
        grid_in = {7{$urandom}};
        check("busy_rise", busy, 1);
        check("grid_hold", grid_out, last_grid);
    endtask

    task automatic wait_done(input int k0);
        exp_t e;
        int   k = k0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 23);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("grid_out", grid_out, e.grid);
            check("lines_cleared", lines_cleared, e.lines);
            check("lines_total", lines_total, e.total);
            check("busy_done", busy, 1);
            last_grid = e.grid;
        end
        @(negedge clk);
        check("done_fall", done, 0);
        check("busy_fall", busy, 0);
    endtask

    task automatic run(input grid_t g);
        start_op(g);
        wait_done(0);
    endtask

    grid_t g;
    grid_t g2;
    int    dc;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        grid_in = '0;
        repeat (3) @(negedge clk);
        check("rst_grid_out", grid_out, 0);
        check("rst_lines_cleared", lines_cleared, 0);
        check("rst_lines_total", lines_total, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        g = '0;
        run(g);

        g = '0; g[21] = 10'h3FF; g[20] = 10'h010;
        run(g);

        g = '0; g[21] = 10'h3FF; g[20] = 10'h3FF; g[19] = 10'h3FF; g[18] = 10'h3FF;
        g[17] = 10'h030; g[16] = 10'h001;
        run(g);

        g = '0; g[21] = 10'h3FF; g[20] = 10'h155; g[19] = 10'h3FF; g[18] = 10'h2AA;
        run(g);

        g = '1;
        run(g);

        // start re-pulsed during SCAN with different data must be ignored
        g = '0; g[21] = 10'h3FF; g[10] = 10'h3FE; g[3] = 10'h3FF; g[0] = 10'h201;
        g2 = '0; g2[21] = 10'h0F0;
        dc = done_count;
        start_op(g);
        repeat (4) @(negedge clk);
        grid_in = g2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(5);
        repeat (30) @(negedge clk);
        check("single_done", done_count - dc, 1);
        check("sb_drained", sb.size(), 0);

        // asynchronous reset in the middle of SCAN
        g = '0; g[21] = 10'h3FF; g[15] = 10'h011;
        start_op(g);
        dc = done_count;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_grid_out", grid_out, 0);
        check("abort_lines_total", lines_total, 0);
        check("abort_lines_cleared", lines_cleared, 0);
        sb.delete();
        model_total = 0;
        last_grid   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", done_count - dc, 0);
        run(g);

        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < 22; r++) begin
                g[r] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom);
            end
            run(g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/line_clear.md
# line_clear

Sequential row-clear stage that sits directly downstream of the falling-piece stage. When a piece has landed, it receives the merged 22×10 playfield and removes every completely filled row. It then compacts the remaining rows toward the bottom (row 21) and zero-fills the top. The cleaned grid and the per-drop and running line counts go back to the game controller.

## Interface
Parameters: none. Geometry is fixed at 22 rows × 10 columns; row 0 is the top row and row 21 is the bottom row.

Ports (clock and reset first):
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- grid_in  input  [21:0][9:0]  landed playfield; sampled on the start edge only.
- grid_out  output  [21:0][9:0]  cleaned playfield; registered; changes only on entry to DONE.
- lines_cleared  output  5  number of full rows removed by the last operation (0..22); registered; changes only on entry to DONE.
- lines_total  output  16  running sum of lines_cleared; saturates at 16'hFFFF.
- busy  output  1  high in SCAN, FILL and DONE.
- done  output  1  one-cycle pulse, high only in DONE.

## Operation
State machine states: IDLE, SCAN, FILL, DONE.

Internal registers:
- work: a 22×10 working array.
- rd: 5-bit read row pointer.
- wr: 5-bit write row pointer.
- cnt: 5-bit count of full rows found.

State behaviour:
- IDLE, start=1: on the edge, work←grid_in, rd←21, wr←21, cnt←0, go to SCAN.
- IDLE, start=0: hold.
- SCAN, one row per cycle:
  - If work[rd] is full (all 10 bits set): cnt←cnt+1; wr unchanged.
  - Otherwise: work[wr]←work[rd], wr←wr−1. A self-copy when rd==wr is legal.
  - In both cases rd←rd−1.
  - When rd==0 is processed, go to FILL. wr may wrap to 31; that value is never used.
- FILL, single cycle: zero every work row with index < cnt. If cnt=0, no row changes. Go to DONE.
- DONE, single cycle:
  - done=1.
  - On entry: grid_out←work and lines_cleared←cnt.
  - lines_total←min(lines_total+cnt, 16'hFFFF), using a 17-bit intermediate.
  - Go to IDLE.

Rules:
- start is ignored whenever busy=1. It is not queued.
- grid_in may change freely after the start edge.
- Relative row order of the non-full rows is preserved.
- A column fill pattern has no effect unless its row is fully set.

## Timing
- Reset values: state=IDLE, grid_out=0, lines_cleared=0, lines_total=0, busy=0, done=0; work, rd, wr and cnt are all 0.
- Reset applied mid-operation aborts immediately. No done pulse is produced and all outputs return to their reset values.
- Let E0 be the edge that samples start:
  - busy rises after E0.
  - SCAN occupies E1..E22, processing rows 21 down to 0.
  - FILL completes at E23.
  - done, grid_out, lines_cleared and lines_total update at E23.
  - done falls and busy falls at E24.
- Fixed latency: 23 cycles from start to done, independent of content.
- The earliest accepted back-to-back start is the cycle after done, i.e. sampled at E24.
- Outputs are stable between updates. The previous grid_out is held throughout an operation.

## Test plan
- Empty grid, start → done at E23; grid_out=0, lines_cleared=0, lines_total=0.
- Row 21 = 10'h3FF, row 20 = 10'h010, all other rows 0 → grid_out row 21 = 10'h010, all other rows 0; lines_cleared=1.
- Rows 18–21 full, row 17 = 10'h030, row 16 = 10'h001 → grid_out row 21 = 10'h030, row 20 = 10'h001, all other rows 0; lines_cleared=4; lines_total=4.
- Rows 21 and 19 full, row 20 = 10'h155, row 18 = 10'h2AA → row 21 = 10'h155, row 20 = 10'h2AA, rows 0–19 = 0; lines_cleared=2. Then all 22 rows full → grid_out=0, lines_cleared=22, lines_total=24.
- start pulsed again at E5 during SCAN → ignored: a single done pulse at E23, with a result matching grid_in from E0.
- rst_n low at E10 during SCAN → busy=0, done never pulses, grid_out=0 and lines_total=0 immediately. A new start after release completes normally.
